// File: rtl/gate_bist.sv
// Self-test controller for a 2-input gate: sweeps all four input vectors PASSES times,
// samples gate_out after a settle interval and reports pass/fail, error count and first failing vector.
module gate_bist #(
    parameter int SETTLE = 2,
    parameter int PASSES = 4,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             gate_out,
    output logic             gate_a,
    output logic             gate_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [1:0]       first_fail_vec
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic [1:0]        v;
    logic [1:0]        op_q;
    logic [15:0]       sweep;
    logic [15:0]       cnt;
    logic              expected;
    logic              mismatch;
    logic              last_vec;
    logic              settle_end;
    logic [ERR_W-1:0]  err_next;

    // The vector counter itself is the registered drive for the gate inputs.
    assign gate_a = v[1];
    assign gate_b = v[0];

    always_comb begin
        case (op_q)
            2'b00:   expected = v[1] & v[0];
            2'b01:   expected = v[1] | v[0];
            2'b10:   expected = v[1] ^ v[0];
            default: expected = ~(v[1] & v[0]);
        endcase
    end

    assign mismatch   = (gate_out != expected);
    assign last_vec   = (v == 2'd3) && (sweep == 16'(PASSES - 1));
    assign settle_end = (cnt == 16'(SETTLE - 1));
    assign err_next   = (mismatch && (err_count != '1)) ? err_count + ERR_W'(1) : err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_DRIVE;
            end
            S_DRIVE:  state_next = (SETTLE == 0) ? S_CHECK : S_SETTLE;
            S_SETTLE: if (settle_end) state_next = S_CHECK;
            S_CHECK:  state_next = last_vec ? S_DONE : S_DRIVE;
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v                <= '0;
            op_q             <= '0;
            sweep            <= '0;
            cnt              <= '0;
            err_count        <= '0;
            pass             <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q             <= op;
                        v                <= '0;
                        sweep            <= '0;
                        err_count        <= '0;
                        pass             <= 1'b0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end
                S_DRIVE:  cnt <= '0;
                S_SETTLE: cnt <= cnt + 16'd1;
                S_CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_vec   <= v;
                    end
                    // pass is resolved here so it is already valid in the DONE cycle.
                    if (last_vec) begin
                        pass <= (err_next == '0);
                    end else begin
                        v <= v + 2'd1;
                        if (v == 2'd3) sweep <= sweep + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: three instances (defaults, ERR_W=3, SETTLE=0/PASSES=1) driven by a
// behavioural gate model with injectable faults, checked against a sweep-level reference.
module tb_gate_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] start_s;
    logic [1:0] op_s [3];
    logic [1:0] fn_s [3];
    logic [3:0] fault_s [3];
    logic [2:0] gout;
    logic [2:0] ga, gb, busy, done, pass, ffv;
    logic [1:0] ffvec [3];
    logic [7:0] ec0, ec2;
    logic [2:0] ec1;
    logic [7:0] errc [3];

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    localparam int S_OF [3] = '{2, 2, 0};
    localparam int P_OF [3] = '{4, 4, 1};
    localparam int EMAX [3] = '{255, 7, 255};

    assign errc[0] = ec0;
    assign errc[1] = {5'd0, ec1};
    assign errc[2] = ec2;

    function automatic logic truth(input logic [1:0] f, input logic a, input logic b);
        case (f)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    always_comb begin
        gout = '0;
        for (int i = 0; i < 3; i++)
            gout[i] = truth(fn_s[i], ga[i], gb[i]) ^ fault_s[i][{ga[i], gb[i]}];
    end

    gate_bist u_def (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .op(op_s[0]), .gate_out(gout[0]),
        .gate_a(ga[0]), .gate_b(gb[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(ec0), .first_fail_valid(ffv[0]), .first_fail_vec(ffvec[0])
    );

    gate_bist #(.ERR_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .op(op_s[1]), .gate_out(gout[1]),
        .gate_a(ga[1]), .gate_b(gb[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(ec1), .first_fail_valid(ffv[1]), .first_fail_vec(ffvec[1])
    );

    gate_bist #(.SETTLE(0), .PASSES(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .op(op_s[2]), .gate_out(gout[2]),
        .gate_a(ga[2]), .gate_b(gb[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(ec2), .first_fail_valid(ffv[2]), .first_fail_vec(ffvec[2])
    );

    task automatic check_idle_reset(input int i, input string name);
        n_assert++;
        if ({ga[i], gb[i], busy[i], done[i], pass[i], errc[i], ffv[i], ffvec[i]} !== 15'd0) begin
            n_fail++;
            $display("FAIL %s inst%0d outputs a=%b b=%b busy=%b done=%b pass=%b err=%0d ffv=%b vec=%b, required all zero",
                     name, i, ga[i], gb[i], busy[i], done[i], pass[i], errc[i], ffv[i], ffvec[i]);
        end
    endtask

    // One full run on instance i; the reference derives results from the truth tables alone.
    task automatic run(input int i, input logic [1:0] o, input logic [1:0] f,
                       input logic [3:0] flt, input bit disturb, input string name);
        int s = S_OF[i];
        int p = P_OF[i];
        int lat = 1 + 4 * p * (s + 2);
        int exp_err = 0;
        int first = -1;
        int exp_vec;
        bit exp_pass;
        for (int v = 0; v < 4; v++) begin
            if ((truth(f, v[1], v[0]) ^ flt[v]) != truth(o, v[1], v[0])) begin
                exp_err += p;
                if (first < 0) first = v;
            end
        end
        if (exp_err > EMAX[i]) exp_err = EMAX[i];
        exp_pass = (exp_err == 0);

        @(negedge clk);
        op_s[i] = o; fn_s[i] = f; fault_s[i] = flt; start_s[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[i] = 1'b0;
        for (int n = 1; n <= lat + 2; n++) begin
            if (disturb && n == 5) begin start_s[i] = 1'b1; op_s[i] = ~o; end
            if (disturb && n == 6) begin start_s[i] = 1'b0; op_s[i] = 2'($urandom); end
            exp_vec = (n < lat) ? ((n - 1) / (s + 2)) % 4 : 3;
            n_assert++;
            if ({ga[i], gb[i]} !== 2'(exp_vec)) begin
                n_fail++;
                $display("FAIL %s vector n=%0d got %b%b required %0d", name, n, ga[i], gb[i], exp_vec);
            end
            n_assert++;
            if (busy[i] !== (n <= lat)) begin
                n_fail++;
                $display("FAIL %s busy n=%0d got %b required %b", name, n, busy[i], (n <= lat));
            end
            n_assert++;
            if (done[i] !== (n == lat)) begin
                n_fail++;
                $display("FAIL %s done n=%0d got %b required %b", name, n, done[i], (n == lat));
            end
            if (n >= lat) begin
                n_assert++;
                if (errc[i] !== 8'(exp_err) || pass[i] !== exp_pass) begin
                    n_fail++;
                    $display("FAIL %s result n=%0d err=%0d pass=%b required err=%0d pass=%b",
                             name, n, errc[i], pass[i], exp_err, exp_pass);
                end
                n_assert++;
                if (ffv[i] !== (first >= 0) || (first >= 0 && ffvec[i] !== 2'(first))) begin
                    n_fail++;
                    $display("FAIL %s first_fail valid=%b vec=%b required valid=%b vec=%0d",
                             name, ffv[i], ffvec[i], (first >= 0), first);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3;
        for (int i = 0; i < 3; i++) check_idle_reset(i, "reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run(0, 2'b00, 2'b00, 4'b0000, 1'b0, "and_good");
        run(0, 2'b00, 2'b00, 4'b0111, 1'b0, "stuck1");
        run(0, 2'b10, 2'b00, 4'b0000, 1'b0, "xor_on_and");
        run(1, 2'b00, 2'b00, 4'b0111, 1'b0, "saturate");
        run(2, 2'b11, 2'b11, 4'b0000, 1'b0, "fast_nand");
    endtask

    task automatic test_disturb();
        run(0, 2'b01, 2'b01, 4'b0000, 1'b1, "disturb_good");
        run(2, 2'b10, 2'b10, 4'b0100, 1'b1, "disturb_fault");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++)
            run(int'($urandom_range(0, 2)), 2'($urandom), 2'($urandom),
                (t % 3 == 0) ? 4'b0000 : 4'($urandom), 1'b0, "random");
    endtask

    task automatic test_midrun_reset();
        @(negedge clk);
        op_s[0] = 2'b00; fn_s[0] = 2'b00; fault_s[0] = 4'b0111; start_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (29) @(negedge clk);
        n_assert++;
        if (ffv[0] !== 1'b1 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_pre ffv=%b busy=%b required 1 1", ffv[0], busy[0]);
        end
        #2 rst_n = 1'b0;
        #1 check_idle_reset(0, "midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 80; n++) begin
            n_assert++;
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL after_reset n=%0d done=%b busy=%b required 0 0", n, done[0], busy[0]);
            end
            @(negedge clk);
        end
        run(0, 2'b11, 2'b11, 4'b0000, 1'b0, "after_reset_run");
    endtask

    initial begin
        start_s = '0;
        for (int i = 0; i < 3; i++) begin
            op_s[i] = '0; fn_s[i] = '0; fault_s[i] = '0;
        end
        test_reset();
        test_directed();
        test_disturb();
        test_random();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
